sram_nxw: RTL

SRAM_NXW -- requirements
Module: sram_nxw

---
 rtl/sram_pkg.sv | 7 +
 rtl/sram_word.sv | 12 +
 rtl/sram_nxw.sv | 81 ++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// sram_pkg: shared FSM state encoding and depth derivation for sram_nxw
package sram_pkg;
  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;
  function automatic int unsigned depth_f(input int unsigned aw);
    return 32'd1 << aw;
  endfunction
endpackage

// File: rtl/sram_word.sv
// sram_word: one DATA_W-bit storage word, synchronous write, no reset
module sram_word #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);
  always_ff @(posedge i_clk)
    if (i_we) o_q <= i_d;
endmodule

// File: rtl/sram_nxw.sv
// sram_nxw: DEPTH x DATA_W single-port SRAM that self-zeroes after reset or i_clr.
// Define SRAM_NXW_BYPASS_EN to forward the previous cycle's write into a same-address read.
module sram_nxw
  import sram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cs_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_ready
);
  localparam int DEPTH = depth_f(ADDR_W);
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] q [DEPTH];
  logic [DEPTH-1:0]  we_v;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd_word;
  logic              acc, wr, rd;
  // i_clr wins over any access issued in the same cycle
  always_comb begin
    acc = state == READY && !i_clr && !i_cs_n;
    wr  = acc && i_we;
    rd  = acc && !i_we;
    wd  = state == CLEAR ? '0 : i_wdata;
    for (int k = 0; k < DEPTH; k++)
      we_v[k] = state == CLEAR ? cnt == ADDR_W'(k) : wr && i_addr == ADDR_W'(k);
  end
  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    sram_word #(.DATA_W(DATA_W)) u_word (
      .i_clk(i_clk),
      .i_we (we_v[g]),
      .i_d  (wd),
      .o_q  (q[g])
    );
  end
`ifdef SRAM_NXW_BYPASS_EN
  logic              wr_v;
  logic [ADDR_W-1:0] wr_a;
  logic [DATA_W-1:0] wr_d;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_v <= 1'b0;
      wr_a <= '0;
      wr_d <= '0;
    end else begin
      wr_v <= wr;
      wr_a <= i_addr;
      wr_d <= i_wdata;
    end
  assign rd_word = wr_v && wr_a == i_addr ? wr_d : q[i_addr];
`else
  assign rd_word = q[i_addr];
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state    <= CLEAR;
      cnt      <= '0;
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= rd;
      if (rd) o_rdata <= rd_word;
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) state <= READY;
      end else if (i_clr) begin
        state <= CLEAR;
        cnt   <= '0;
      end
    end
  assign o_ready = state == READY;
endmodule
